// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 scan counters, pixel coordinates and tile-map lookup.
// hsync/vsync/de run through a short delay line to meet the draw register.
module vga_scan #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int TILE_LOG2 = 4,
  parameter int MAP_W     = 40,
  parameter int MAP_H     = 30,
  parameter int SYNC_DLY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       map_we,
  input  logic [5:0] map_wx,
  input  logic [4:0] map_wy,
  input  logic [1:0] map_wdata,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [1:0] entity,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = AW + 1;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic active;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  logic [1:0]    mem [DEPTH];
  logic [RW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [1:0]    rdata;
  logic          wr_ok;

  // blanking addresses can run past the map, so reads are range-guarded
  always_comb begin
    raddr = RW'(int'(v_cnt >> TILE_LOG2) * MAP_W
              + int'(h_cnt >> TILE_LOG2));
    rdata = '0;
    if (raddr < RW'(DEPTH))
      rdata = mem[raddr[AW-1:0]];
    waddr = AW'(int'(map_wy) * MAP_W + int'(map_wx));
    wr_ok = map_we
         && (map_wx < 6'(MAP_W))
         && (map_wy < 5'(MAP_H));
  end

  // read-first: stage 1 samples the old word on the same edge as a write
  always_ff @(posedge vga_clk) begin
    if (wr_ok)
      mem[waddr] <= map_wdata;
  end

  logic hs1;
  logic vs1;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      entity      <= '0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
    end else begin
      x           <= active ? h_cnt : '0;
      y           <= active ? v_cnt[8:0] : '0;
      entity      <= active ? rdata : '0;
      video_on    <= active;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      hs1         <= hs_raw;
      vs1         <= vs_raw;
    end
  end

  logic [SYNC_DLY-1:0] hs_d;
  logic [SYNC_DLY-1:0] vs_d;
  logic [SYNC_DLY-1:0] de_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_d <= '1;
      vs_d <= '1;
      de_d <= '0;
    end else begin
      hs_d[0] <= hs1;
      vs_d[0] <= vs1;
      de_d[0] <= video_on;
      for (int i = 1; i < SYNC_DLY; i++) begin
        hs_d[i] <= hs_d[i-1];
        vs_d[i] <= vs_d[i-1];
        de_d[i] <= de_d[i-1];
      end
    end
  end

  assign hsync = hs_d[SYNC_DLY-1];
  assign vsync = vs_d[SYNC_DLY-1];
  assign de    = de_d[SYNC_DLY-1];

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: scoreboard bench for vga_scan at full timing, plus a
// reduced-timing instance for frame-level periods.
module tb_vga_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rst_s;
  logic       we;
  logic [5:0] wx;
  logic [4:0] wy;
  logic [1:0] wd;

  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] ent;
  logic       vo, fs, hs, vs, de;

  logic [9:0] s_x;
  logic [8:0] s_y;
  logic [1:0] s_ent;
  logic       s_vo, s_fs, s_hs, s_vs, s_de;

  vga_scan u_dut (
    .vga_clk(clk), .reset(rst),
    .map_we(we), .map_wx(wx), .map_wy(wy), .map_wdata(wd),
    .x(x), .y(y), .entity(ent), .video_on(vo),
    .frame_start(fs), .hsync(hs), .vsync(vs), .de(de)
  );

  // 80 x 55 total, 64 x 48 active: frame period 4400 cycles
  vga_scan #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .vga_clk(clk), .reset(rst_s),
    .map_we(1'b0), .map_wx(6'd0), .map_wy(5'd0), .map_wdata(2'd0),
    .x(s_x), .y(s_y), .entity(s_ent), .video_on(s_vo),
    .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .de(s_de)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] ent;
    logic       vo;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

  pix_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         mh, mv;
  logic [1:0] mram [1200];
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  logic [1:0] s1_ent;
  logic       s1_vo, s1_fs, s1_hs, s1_vs;
  logic       d_hs, d_vs, d_de;

  task automatic model_step();
    logic act;
    if (rst) begin
      {s1_x, s1_y, s1_ent, s1_vo, s1_fs} = '0;
      s1_hs = 1'b1; s1_vs = 1'b1;
      d_hs = 1'b1; d_vs = 1'b1; d_de = 1'b0;
      mh = 0; mv = 0;
    end else begin
      d_hs = s1_hs; d_vs = s1_vs; d_de = s1_vo;
      act = (mh < 640) && (mv < 480);
      s1_x = act ? 10'(mh) : 10'd0;
      s1_y = act ? 9'(mv) : 9'd0;
      s1_ent = act ? mram[(mv / 16) * 40 + mh / 16] : 2'b00;
      s1_vo = act;
      s1_fs = (mh == 0) && (mv == 0);
      s1_hs = !((mh >= 656) && (mh < 752));
      s1_vs = !((mv >= 490) && (mv < 492));
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv++;
        if (mv == 525) mv = 0;
      end
    end
    if (we && wx < 40 && wy < 30)
      mram[int'(wy) * 40 + int'(wx)] = wd;
    exp_q.push_back({s1_x, s1_y, s1_ent, s1_vo, s1_fs,
                     d_hs, d_vs, d_de});
  endtask

  int   rel = 0, rel_s = 0;
  logic prev_hs = 1'b1;
  int   first_fall = 0, second_fall = 0, lo_w = 0, lo_run = 0;
  int   n01 = 0, n11 = 0;

  int nfs = 0;
  int fs_t [3];
  int s_vlow = 0, s_hlow = 0, s_vot = 0, s_det = 0;
  int s_run = 0, s_runs = 0, s_bad = 0;

  task automatic cycle();
    pix_t e;
    bit   win;
    @(posedge clk);
    model_step();
    rel   = rst ? 0 : rel + 1;
    rel_s = rst_s ? 0 : rel_s + 1;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("pix", {x, y, ent, vo, fs, hs, vs, de}, e);
    end
    if (rst) begin
      first_fall = 0; second_fall = 0; lo_w = 0; lo_run = 0;
    end else begin
      if (prev_hs && !hs) begin
        if (first_fall == 0) first_fall = rel;
        else if (second_fall == 0) second_fall = rel;
      end
      if (!hs) lo_run++;
      else if (lo_run != 0) begin
        if (lo_w == 0) lo_w = lo_run;
        lo_run = 0;
      end
    end
    prev_hs = hs;
    if (ent == 2'b01) n01++;
    if (ent == 2'b11) n11++;
    if (!rst_s) begin
      if (s_fs) begin
        if (nfs < 3) fs_t[nfs] = rel_s;
        nfs++;
      end
      win = (nfs >= 1) && (nfs <= 2);
      if (win) begin
        if (!s_vs) s_vlow++;
        if (!s_hs) s_hlow++;
        if (s_vo) s_vot++;
        if (s_de) s_det++;
        if (!s_vo && (s_x != 0 || s_y != 0 || s_ent != 0)) s_bad++;
      end
      if (s_vo) s_run++;
      else if (s_run != 0) begin
        if (win) begin
          s_runs++;
          if (s_run != 64) s_bad++;
        end
        s_run = 0;
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; rst_s = 1'b1; we = 1'b0;
    wx = '0; wy = '0; wd = '0;
    mh = 0; mv = 0;
    for (int i = 0; i < 1200; i++) mram[i] = 2'b00;
    {s1_x, s1_y, s1_ent, s1_vo, s1_fs} = '0;
    s1_hs = 1'b1; s1_vs = 1'b1;
    d_hs = 1'b1; d_vs = 1'b1; d_de = 1'b0;

    // clear the map while in reset
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) begin
        we = 1'b1; wx = 6'(c); wy = 5'(r); wd = 2'b00;
        cycle();
      end
    we = 1'b0;
    cycle();
    cycle();
    chk("rst_hsync", 32'(hs), 32'd1);
    chk("rst_vsync", 32'(vs), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_fs", 32'(fs), 32'd0);

    rst = 1'b0; rst_s = 1'b0;
    cycle();
    chk("fs_first", 32'(fs), 32'd1);
    chk("x_first", 32'(x), 32'd0);

    we = 1'b1; wx = 6'd2; wy = 5'd1; wd = 2'b01;
    cycle();
    wx = 6'd40; wy = 5'd0; wd = 2'b11;
    cycle();
    wx = 6'd0; wy = 5'd30; wd = 2'b11;
    cycle();
    we = 1'b0;

    while (rel < 1700) cycle();
    chk("hs_first_fall", 32'(first_fall), 32'd658);
    chk("hs_period", 32'(second_fall - first_fall), 32'd800);
    chk("hs_low_width", 32'(lo_w), 32'd96);

    while (rel < 34 * 800) cycle();
    chk("ent01_count", 32'(n01), 32'd256);
    chk("ent11_count", 32'(n11), 32'd0);

    chk("small_nfs", 32'(nfs >= 3), 32'd1);
    chk("small_period1", 32'(fs_t[1] - fs_t[0]), 32'd4400);
    chk("small_period2", 32'(fs_t[2] - fs_t[1]), 32'd4400);
    chk("small_vs_low", 32'(s_vlow), 32'd320);
    chk("small_hs_low", 32'(s_hlow), 32'd880);
    chk("small_vo_total", 32'(s_vot), 32'd6144);
    chk("small_de_total", 32'(s_det), 32'd6144);
    chk("small_vo_lines", 32'(s_runs), 32'd96);
    chk("small_bad", 32'(s_bad), 32'd0);

    // mid-frame reset at h_cnt=300
    guard = 0;
    while (mh != 300 && guard < 1000) begin
      cycle();
      guard++;
    end
    rst = 1'b1;
    repeat (3) cycle();
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_vo", 32'(vo), 32'd0);
    chk("mid_rst_hsync", 32'(hs), 32'd1);
    chk("mid_rst_de", 32'(de), 32'd0);
    rst = 1'b0;
    cycle();
    chk("fs_after_rst", 32'(fs), 32'd1);
    chk("y_after_rst", 32'(y), 32'd0);

    // write tile (0,0) on the cycle the counters sit at h=5,v=0
    guard = 0;
    while (!(mh == 5 && mv == 0) && guard < 1000) begin
      cycle();
      guard++;
    end
    we = 1'b1; wx = 6'd0; wy = 5'd0; wd = 2'b10;
    cycle();
    we = 1'b0;
    chk("rf_x5", 32'(x), 32'd5);
    chk("rf_ent_x5", 32'(ent), 32'd0);
    cycle();
    chk("rf_x6", 32'(x), 32'd6);
    chk("rf_ent_x6", 32'(ent), 32'd2);

    while (rel < 1700) cycle();
    chk("rst_hs_first_fall", 32'(first_fall), 32'd658);
    chk("rst_hs_period", 32'(second_fall - first_fall), 32'd800);
    chk("rst_hs_low_width", 32'(lo_w), 32'd96);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
